fruit_sprite_scheduler: RTL and testbench
=========================================

# fruit_sprite_scheduler

Shares one 50x50 fruit sprite ROM pipeline (image RAM + colour palette, registered reads) among NUM_FRUIT on-screen fruit instances. Per pixel it resolves which fruit covers the current (x, y), generates the sprite ROM address, carries the hit information through the ROM latency, and outputs the final 12-bit colour: sprite over background. Fruit positions are written by game logic into a pending bank at any time and committed to the active bank only at frame start, so a frame never shows a mix of old and new positions.

## Interface
- NUM_FRUIT, 4, number of fruit slots (2..8)
- FRUIT_SIZE, 50, sprite edge length in pixels
- ROM_LATENCY, 2, cycles from rom_addr to rom_data (image RAM + palette RAM)
- ADDR_W, 13, sprite ROM address width ($clog2(FRUIT_SIZE*FRUIT_SIZE)+1)
- TRANSPARENT, 12'h0F0, rom_data value treated as see-through
- IDX_W, $clog2(NUM_FRUIT), slot index width
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- x  in  10  current pixel column
- y  in  9  current pixel row
- pix_valid  in  1  x/y is inside the active 640x480 area
- frame_start  in  1  one-cycle pulse at start of vertical blank
- set_valid  in  1  write pending slot set_idx this cycle
- set_idx  in  IDX_W  slot being written
- set_x  in  10  new top-left column
- set_y  in  9  new top-left row
- set_en  in  1  slot visible (0 hides the slot)
- rom_addr  out  ADDR_W  address to the shared sprite ROM
- rom_data  in  12  colour returned by the sprite ROM
- bg_color  in  12  background colour, aligned with rom_data
- out_color  out  12  composed pixel colour
- out_valid  out  1  out_color corresponds to an active pixel
- out_hit  out  1  a visible, non-transparent fruit pixel was output
- out_idx  out  IDX_W  slot that won the pixel (valid when out_hit)

## Operation
- Two register banks per slot: pending {x, y, en} and active {x, y, en}. All reset to 0 (all slots hidden).
- set_valid=1: pending[set_idx] <= {set_x, set_y, set_en} at the rising edge. set_idx >= NUM_FRUIT: write ignored.
- frame_start=1: active <= pending for all slots. Same-cycle set_valid writes pending only; commit uses pre-write pending, so that write appears from the next frame.
- Hit test per slot i (active bank): en_i && x >= fx_i && x < fx_i+FRUIT_SIZE && y >= fy_i && y < fy_i+FRUIT_SIZE. Compare in 11-bit (x) / 10-bit (y) so fx+50 > 1023 cannot wrap. pix_valid=0 forces no hit.
- Priority: lowest slot index wins overlaps.
- Stage S0 (registered): rom_addr <= (x-fx_w) + FRUIT_SIZE*(y-fy_w), computed unsigned at ADDR_W; rom_addr <= 0 on no hit. hit, idx, pix_valid registered alongside.
- Stages S1..S_ROM_LATENCY: hit/idx/pix_valid delayed in a shift register matching ROM latency.
- Output stage (registered): sprite = hit_d && rom_data != TRANSPARENT. out_color <= sprite ? rom_data : bg_color; out_hit <= sprite; out_idx <= sprite ? idx_d : 0; out_valid <= pix_valid_d. When pix_valid_d=0, out_color <= 12'h000.
- No state besides banks and pipeline; pipeline is free-running, never stalls.

## Timing
- Reset (resetn=0, asynchronous): rom_addr=0, out_color=0, out_valid=0, out_hit=0, out_idx=0, both banks cleared, delay pipeline cleared. Release is synchronous to next clk edge.
- Reset mid-frame: pipeline flushed; all fruits hidden until a set_valid write followed by a frame_start.
- Latency x/y -> out_color: 1 + ROM_LATENCY + 1 = 4 cycles at defaults. rom_addr valid 1 cycle after x/y.
- bg_color must be presented ROM_LATENCY+1 cycles after its x/y (same cycle as matching rom_data).
- Commit: active bank changes at the frame_start edge; pixels sampled from the following cycle use new positions.
- Throughput: one pixel per cycle, back-to-back.

## Test plan
- Reset: hold resetn=0 mid-stream with pix_valid=1 -> out_valid=0, out_color=0, rom_addr=0; after release, no hits until write+commit.
- Single fruit: slot0 at (100,200) en, frame_start; scan (125,210) -> rom_addr=525 one cycle later; rom_data=12'hF00 -> out_color=12'hF00, out_hit=1, out_idx=0 four cycles after x/y.
- Boundaries: slot0 at (100,200): (149,249) hits, addr=2499; (150,200) and (100,250) miss -> out_color=bg_color, out_hit=0; slot at (620,470) with x=639 hits, no wrap.
- Overlap/transparency: slot1 and slot2 both at (300,300); pixel (310,310) -> out_idx=1; rom_data=12'h0F0 -> out_color=bg_color, out_hit=0.
- Commit: write slot0 to (400,100) with no frame_start -> old position still rendered; pulse frame_start together with set_valid moving slot0 to (0,0) -> (400,100) active next frame, (0,0) only after second frame_start.
- Hide: set_en=0 on slot0 + frame_start -> no hits for slot0 anywhere; set_idx=NUM_FRUIT write -> no bank change.

Source files
------------

// File: rtl/fruit_sprite_scheduler.sv
// Shares one fruit sprite ROM pipeline among NUM_FRUIT on-screen fruit instances,
// with double-buffered positions committed at frame start and sprite-over-background output.
module fruit_sprite_scheduler #(
  parameter int          NUM_FRUIT   = 4,
  parameter int          FRUIT_SIZE  = 50,
  parameter int          ROM_LATENCY = 2,
  parameter int          ADDR_W      = 13,
  parameter logic [11:0] TRANSPARENT = 12'h0F0,
  parameter int          IDX_W       = $clog2(NUM_FRUIT)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic              set_valid,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [9:0]        set_x,
  input  logic [8:0]        set_y,
  input  logic              set_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  input  logic [11:0]       bg_color,
  output logic [11:0]       out_color,
  output logic              out_valid,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_idx
);

  logic [9:0] pendX [NUM_FRUIT];
  logic [8:0] pendY [NUM_FRUIT];
  logic       pendEn [NUM_FRUIT];
  logic [9:0] actX [NUM_FRUIT];
  logic [8:0] actY [NUM_FRUIT];
  logic       actEn [NUM_FRUIT];

  logic [NUM_FRUIT-1:0] slotHit;
  logic                 anyHit;
  logic [IDX_W-1:0]     winIdx;
  logic [9:0]           dx;
  logic [8:0]           dy;
  logic [ADDR_W-1:0]    nextAddr;

  logic             hitS0;
  logic             pvS0;
  logic [IDX_W-1:0] idxS0;

  logic [ROM_LATENCY-1:0] hitPipe;
  logic [ROM_LATENCY-1:0] pvPipe;
  logic [IDX_W-1:0]       idxPipe [ROM_LATENCY];

  logic sprite;

  // Commit reads the pre-write pending bank, so a same-cycle write lands in the next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_FRUIT; i++) begin
        pendX[i]  <= '0;
        pendY[i]  <= '0;
        pendEn[i] <= 1'b0;
        actX[i]   <= '0;
        actY[i]   <= '0;
        actEn[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_FRUIT; i++) begin
        if (frame_start) begin
          actX[i]  <= pendX[i];
          actY[i]  <= pendY[i];
          actEn[i] <= pendEn[i];
        end
        if (set_valid && set_idx == IDX_W'(i)) begin
          pendX[i]  <= set_x;
          pendY[i]  <= set_y;
          pendEn[i] <= set_en;
        end
      end
    end
  end

  // Widened compares keep fx+FRUIT_SIZE from wrapping near the coordinate limits.
  always_comb begin
    slotHit = '0;
    for (int i = 0; i < NUM_FRUIT; i++) begin
      slotHit[i] = pix_valid && actEn[i]
                   && ({1'b0, x} >= {1'b0, actX[i]})
                   && ({1'b0, x} <  ({1'b0, actX[i]} + 11'(FRUIT_SIZE)))
                   && ({1'b0, y} >= {1'b0, actY[i]})
                   && ({1'b0, y} <  ({1'b0, actY[i]} + 10'(FRUIT_SIZE)));
    end
  end

  always_comb begin
    anyHit   = 1'b0;
    winIdx   = '0;
    dx       = '0;
    dy       = '0;
    nextAddr = '0;
    for (int i = 0; i < NUM_FRUIT; i++) begin
      if (!anyHit && slotHit[i]) begin
        anyHit = 1'b1;
        winIdx = IDX_W'(i);
        dx     = x - actX[i];
        dy     = y - actY[i];
      end
    end
    if (anyHit) begin
      nextAddr = ADDR_W'(dx) + ADDR_W'(FRUIT_SIZE) * ADDR_W'(dy);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rom_addr <= '0;
      hitS0    <= 1'b0;
      pvS0     <= 1'b0;
      idxS0    <= '0;
    end else begin
      rom_addr <= nextAddr;
      hitS0    <= anyHit;
      pvS0     <= pix_valid;
      idxS0    <= winIdx;
    end
  end

  // Hit information rides alongside the ROM read so it meets rom_data in the output stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hitPipe <= '0;
      pvPipe  <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) idxPipe[i] <= '0;
    end else begin
      hitPipe[0] <= hitS0;
      pvPipe[0]  <= pvS0;
      idxPipe[0] <= idxS0;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        hitPipe[i] <= hitPipe[i-1];
        pvPipe[i]  <= pvPipe[i-1];
        idxPipe[i] <= idxPipe[i-1];
      end
    end
  end

  assign sprite = hitPipe[ROM_LATENCY-1] && (rom_data != TRANSPARENT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_color <= '0;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
    end else begin
      out_valid <= pvPipe[ROM_LATENCY-1];
      out_hit   <= sprite;
      out_idx   <= sprite ? idxPipe[ROM_LATENCY-1] : '0;
      if (!pvPipe[ROM_LATENCY-1]) out_color <= 12'h000;
      else                        out_color <= sprite ? rom_data : bg_color;
    end
  end

endmodule

// File: tb/tb_fruit_sprite_scheduler.sv
// Scoreboard bench for fruit_sprite_scheduler: emulates a two-stage sprite ROM and
// aligned background, predicts rom_addr and composed output from a position model.
module tb_fruit_sprite_scheduler;

  localparam int NF = 3;
  localparam int IW = 2;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          resetn;
  logic [9:0]    x;
  logic [8:0]    y;
  logic          pix_valid;
  logic          frame_start;
  logic          set_valid;
  logic [IW-1:0] set_idx;
  logic [9:0]    set_x;
  logic [8:0]    set_y;
  logic          set_en;
  logic [AW-1:0] rom_addr;
  logic [11:0]   out_color;
  logic          out_valid;
  logic          out_hit;
  logic [IW-1:0] out_idx;

  logic [AW-1:0] romQ1 = '0;
  logic [11:0]   romQ2 = '0;
  logic [11:0]   bgIn  = '0;
  logic [11:0]   bg1 = '0, bg2 = '0, bg3 = '0;

  int cyc = 0;
  int vectorsApplied = 0;
  int miscompares = 0;

  typedef struct {
    int            due;
    logic [11:0]   color;
    logic          valid;
    logic          hit;
    logic [IW-1:0] idx;
  } outExp_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } addrExp_t;

  outExp_t  outQ[$];
  addrExp_t addrQ[$];
  outExp_t  outE;
  addrExp_t addrE;

  int mPendX[NF], mPendY[NF], mPendEn[NF];
  int mActX[NF],  mActY[NF],  mActEn[NF];

  fruit_sprite_scheduler #(.NUM_FRUIT(NF)) dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_start(frame_start), .set_valid(set_valid), .set_idx(set_idx),
    .set_x(set_x), .set_y(set_y), .set_en(set_en), .rom_addr(rom_addr),
    .rom_data(romQ2), .bg_color(bg3), .out_color(out_color),
    .out_valid(out_valid), .out_hit(out_hit), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents; two special addresses give a known opaque and the transparent key.
  function automatic logic [11:0] romColor(input logic [AW-1:0] a);
    logic [11:0] c;
    if (a == AW'(525))      c = 12'hF00;
    else if (a == AW'(510)) c = 12'h0F0;
    else begin
      c = 12'(int'(a) * 7 + 1);
      if (c == 12'h0F0) c = 12'h0F1;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    romQ1 <= rom_addr;
    romQ2 <= romColor(romQ1);
    bg1   <= bgIn;
    bg2   <= bg1;
    bg3   <= bg2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (addrQ.size() > 0 && addrQ[0].due == cyc) begin
        addrE = addrQ.pop_front();
        checkOutput("romAddr", 32'(rom_addr), 32'(addrE.addr));
      end
      if (outQ.size() > 0 && outQ[0].due == cyc) begin
        outE = outQ.pop_front();
        checkOutput("outValid", 32'(out_valid), 32'(outE.valid));
        checkOutput("outColor", 32'(out_color), 32'(outE.color));
        checkOutput("outHit",   32'(out_hit),   32'(outE.hit));
        checkOutput("outIdx",   32'(out_idx),   32'(outE.idx));
      end
    end
  end

  // One input cycle: predict from the model's current active bank, then apply bank updates.
  task automatic applyStimulus(input int px, input int py, input int pv, input int fs,
                               input int sv, input int sidx, input int sx, input int sy, input int sen);
    outExp_t  oe;
    addrExp_t ae;
    int       hitSlot;
    logic [11:0] rc;
    @(negedge clk);
    x = 10'(px); y = 9'(py); pix_valid = 1'(pv); frame_start = 1'(fs);
    set_valid = 1'(sv); set_idx = IW'(sidx); set_x = 10'(sx); set_y = 9'(sy); set_en = 1'(sen);
    bgIn = 12'hA00 + 12'(cyc & 255);
    hitSlot = -1;
    if (pv != 0) begin
      for (int i = 0; i < NF; i++) begin
        if (hitSlot < 0 && mActEn[i] != 0 && px >= mActX[i] && px < mActX[i] + 50
            && py >= mActY[i] && py < mActY[i] + 50) hitSlot = i;
      end
    end
    ae.due  = cyc + 1;
    ae.addr = (hitSlot >= 0) ? AW'((px - mActX[hitSlot]) + 50 * (py - mActY[hitSlot])) : '0;
    rc = romColor(ae.addr);
    oe.due   = cyc + 4;
    oe.valid = 1'(pv);
    oe.hit   = (hitSlot >= 0) && (rc != 12'h0F0);
    oe.idx   = oe.hit ? IW'(hitSlot) : '0;
    oe.color = (pv == 0) ? 12'h000 : (oe.hit ? rc : bgIn);
    if (resetn) begin
      addrQ.push_back(ae);
      outQ.push_back(oe);
    end
    if (fs != 0) begin
      for (int i = 0; i < NF; i++) begin
        mActX[i] = mPendX[i]; mActY[i] = mPendY[i]; mActEn[i] = mPendEn[i];
      end
    end
    if (sv != 0 && sidx >= 0 && sidx < NF) begin
      mPendX[sidx] = sx; mPendY[sidx] = sy; mPendEn[sidx] = sen;
    end
  endtask

  task automatic pix(input int px, input int py);
    applyStimulus(px, py, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic setSlot(input int idx, input int px, input int py, input int en, input int fs);
    applyStimulus(0, 0, 0, fs, 1, idx, px, py, en);
  endtask

  task automatic commit();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic clearModel();
    for (int i = 0; i < NF; i++) begin
      mPendX[i] = 0; mPendY[i] = 0; mPendEn[i] = 0;
      mActX[i]  = 0; mActY[i]  = 0; mActEn[i]  = 0;
    end
  endtask

  // Asynchronous reset with an active pixel on the inputs; outputs must clear at once.
  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    x = 10'd125; y = 9'd210; pix_valid = 1'b1;
    frame_start = 1'b0; set_valid = 1'b0;
    outQ.delete();
    addrQ.delete();
    clearModel();
    #1;
    checkOutput("rstAsyncValid", 32'(out_valid), 32'd0);
    checkOutput("rstAsyncColor", 32'(out_color), 32'd0);
    checkOutput("rstAsyncAddr",  32'(rom_addr),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstHoldValid", 32'(out_valid), 32'd0);
    checkOutput("rstHoldHit",   32'(out_hit),   32'd0);
    checkOutput("rstHoldIdx",   32'(out_idx),   32'd0);
    checkOutput("rstHoldColor", 32'(out_color), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    pix_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    x = '0; y = '0; pix_valid = 1'b0; frame_start = 1'b0;
    set_valid = 1'b0; set_idx = '0; set_x = '0; set_y = '0; set_en = 1'b0;
    clearModel();
    doReset();

    pix(125, 210);
    pix(0, 0);

    setSlot(0, 100, 200, 1, 0);
    commit();
    pix(125, 210);
    pix(149, 249);
    pix(150, 200);
    pix(100, 250);
    pix(99, 200);

    setSlot(2, 620, 470, 1, 0);
    setSlot(1, 1000, 0, 1, 0);
    commit();
    pix(639, 475);
    pix(619, 475);
    pix(1010, 11);
    pix(1023, 49);

    setSlot(1, 300, 300, 1, 0);
    setSlot(2, 300, 300, 1, 0);
    commit();
    pix(311, 310);
    pix(310, 310);
    pix(349, 349);
    pix(350, 349);

    setSlot(0, 400, 100, 1, 0);
    pix(125, 210);
    pix(410, 110);
    setSlot(0, 0, 0, 1, 1);
    pix(410, 110);
    pix(5, 5);
    commit();
    pix(5, 5);
    pix(410, 110);

    setSlot(0, 0, 0, 0, 0);
    commit();
    pix(5, 5);
    pix(0, 0);

    setSlot(3, 5, 5, 1, 0);
    commit();
    pix(5, 5);
    pix(311, 310);

    for (int i = 0; i < 12; i++) pix($urandom_range(280, 360), $urandom_range(280, 360));

    pix(311, 310);
    pix(312, 310);
    doReset();
    pix(311, 310);
    setSlot(1, 300, 300, 1, 0);
    pix(311, 310);
    commit();
    pix(311, 310);
    pix(310, 310);

    idle();
    repeat (6) @(negedge clk);
    checkOutput("drainOut",  32'(outQ.size()),  32'd0);
    checkOutput("drainAddr", 32'(addrQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
